uart_tx_feeder: RTL
===================

# uart_tx_feeder

Transmit-side buffering and launch controller between the APB register file and the UART transmitter. The block queues bytes written by the bus into a synchronous FIFO. It starts one transmitter frame per byte using a single-cycle `tx_enable` pulse, and waits for the transmitter's `tx_done` pulse before starting the next frame. It also reports FIFO status, a sticky overflow flag, and a transmit-complete interrupt pulse.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, at least 2.
- `CNT_W`, `$clog2(DEPTH)+1`, width of `count`.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  push request from the bus write decoder.
- `wr_data`  in  8  byte to queue.
- `cfg_reg`  in  5  live line configuration `{parity_type, parity_en, stop_bits, data_bits[1:0]}`.
- `flush`  in  1  clears all queued bytes.
- `ovf_clr`  in  1  clears `overflow`.
- `tx_done`  in  1  one-cycle frame-complete pulse from the transmitter.
- `tx_enable`  out  1  one-cycle frame start pulse to the transmitter.
- `tx_data`  out  8  byte presented with `tx_enable`.
- `tx_cfg`  out  5  configuration presented with `tx_enable`.
- `full`, `empty`  out  1 each  FIFO status.
- `count`  out  `CNT_W`  number of bytes queued.
- `overflow`  out  1  sticky; set by a push that is rejected because the FIFO is full.
- `tx_irq`  out  1  one-cycle pulse when a frame completes and the FIFO is empty.

## Operation
- FSM states:
  - **IDLE**: moves to LAUNCH when `!empty && !flush`. On that transition, `tx_data` is loaded from the FIFO head and `tx_cfg` is loaded.
  - **LAUNCH**: `tx_enable` = 1 and the head entry is popped. Always moves to WAIT_DONE.
  - **WAIT_DONE**: moves to IDLE on `tx_done`. All other inputs are ignored.
- `tx_enable` is decoded from the state register (state == LAUNCH) and lasts exactly one cycle per byte.
- Push accepted when `wr_en && !full && !flush`. Push while `full` is dropped and sets `overflow`, even if a pop occurs in the same cycle.
- Push and pop in the same cycle: `count` is unchanged and read/write pointers both advance.
- `flush`:
  - Resets pointers and sets `count` to 0.
  - Has priority over push and pop.
  - A `wr_en` in the same cycle is discarded and does not set `overflow`.
  - A byte already in LAUNCH or WAIT_DONE still completes.
- `ovf_clr` has priority over a simultaneous overflow-setting push.
- `tx_irq`:
  - Pulses the cycle after `tx_done` if, in the `tx_done` cycle, `count` = 0 and no push is accepted.
  - Otherwise the FIFO still holds data and the next byte is launched, with no interrupt.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally. `count` saturates only by rule (pushes rejected at `DEPTH`).

## Timing
- Reset values: `tx_enable` 0, `tx_data` 0, `tx_cfg` 0, `full` 0, `empty` 1, `count` 0, `overflow` 0, `tx_irq` 0; state IDLE; pointers 0.
- Push latency: `wr_en` in cycle t with the FIFO empty and state IDLE gives `count` = 1 in t+1 and `tx_enable` high in t+2.
- Back-to-back frames: `tx_done` in cycle d gives IDLE in d+1 and the next `tx_enable` in d+2. This guarantees the transmitter is back in its idle state when `tx_enable` arrives.
- `full`, `empty` and `count` are registered and update the cycle after the push or pop edge.
- Reset mid-frame returns every output to its reset value immediately. Queued data is lost.

## Configuration
- Macro `UART_TX_CFG_PER_BYTE_EN`:
  - **Defined**: each FIFO entry stores `{cfg_reg, wr_data}` (13 bits), sampled at push. `tx_cfg` comes from the head entry.
  - **Undefined**: entries are 8 bits. `tx_cfg` samples live `cfg_reg` on the IDLE→LAUNCH transition.

## Structure
- Package `uart_pkg` holds:
  - the `feeder_state_e` enum (IDLE, LAUNCH, WAIT_DONE);
  - `CFG_W` = 5;
  - cfg field index constants (DATA_BITS lsb 0, STOP_BITS 2, PARITY_EN 3, PARITY_TYPE 4).
- One sub-module, `uart_sync_fifo`:
  - parameterised on width and depth;
  - registered count and flags;
  - flush input.

## Test plan
- **Reset**: assert `rst_n` low mid-WAIT_DONE with 3 bytes queued → all outputs at reset values, `empty` = 1, no `tx_enable` after release.
- **Single byte**: push 0xA5 with `cfg_reg` = 5'b00011 in cycle 0 → `tx_enable` high only in cycle 2 with `tx_data` = 0xA5 and `tx_cfg` = 5'b00011; pulse `tx_done` in cycle 40 → `tx_irq` high in cycle 41 only.
- **Overflow**: push 0x00..0x11 on 18 consecutive cycles, `tx_done` held low → first 17 pushes accepted (one byte launched), `full` = 1, the 18th push drops and sets `overflow`; `ovf_clr` → 0.
- **Back-to-back**: queue 0x11, 0x22; `tx_done` in cycle d → second `tx_enable` in d+2 with `tx_data` 0x22, no `tx_irq`; after the second `tx_done` → `tx_irq` pulse.
- **Flush**: 3 bytes queued in WAIT_DONE, pulse `flush` together with `wr_en` → `count` 0, no overflow, no further `tx_enable` after `tx_done`, `tx_irq` pulses.
- **Config sampling**:
  - Macro defined: push 0x11 with cfg 0x03, then 0x22 with cfg 0x1C → `tx_cfg` 0x03 then 0x1C.
  - Macro undefined: `tx_cfg` equals `cfg_reg` at each launch.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit feeder.
package uart_pkg;

  localparam int unsigned CFG_W  = 5;
  localparam int unsigned DATA_W = 8;

  // Bit positions inside cfg_reg / tx_cfg.
  localparam int unsigned CFG_DATA_BITS_LSB = 0;
  localparam int unsigned CFG_STOP_BITS     = 2;
  localparam int unsigned CFG_PARITY_EN     = 3;
  localparam int unsigned CFG_PARITY_TYPE   = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } feeder_state_e;

  // FIFO entry when configuration is captured per byte.
  typedef struct packed {
    logic [CFG_W-1:0]  cfg;
    logic [DATA_W-1:0] data;
  } tx_entry_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Bus-side and transmitter-side signals of the UART transmit feeder.
interface uart_tx_feeder_if #(
  parameter int unsigned DEPTH = 16
);
  import uart_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [CFG_W-1:0]  cfg_reg;
  logic              flush;
  logic              ovf_clr;
  logic              tx_done;

  logic              tx_enable;
  logic [DATA_W-1:0] tx_data;
  logic [CFG_W-1:0]  tx_cfg;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              tx_irq;

  modport master (
    output wr_en, wr_data, cfg_reg, flush, ovf_clr, tx_done,
    input  tx_enable, tx_data, tx_cfg, full, empty, count, overflow, tx_irq
  );

  modport slave (
    input  wr_en, wr_data, cfg_reg, flush, ovf_clr, tx_done,
    output tx_enable, tx_data, tx_cfg, full, empty, count, overflow, tx_irq
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered count/flags and a synchronous flush.
module uart_sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata_c,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;

  // Qualify requests against the registered flags; flush overrides both.
  always_comb begin
    w_push      = i_push && !r_full && !i_flush;
    w_pop       = i_pop && !r_empty && !i_flush;
    w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage; entries are only read after being written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata_c = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;
  assign o_count   = r_count;

endmodule

// File: rtl/uart_tx_feeder.sv
// Transmit feeder: queues bus bytes and launches one UART frame per byte.
// Build option: UART_TX_CFG_PER_BYTE_EN stores cfg_reg with each byte;
// otherwise tx_cfg samples the live cfg_reg when a frame is launched.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_feeder_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
`ifdef UART_TX_CFG_PER_BYTE_EN
  localparam int unsigned ENTRY_W = CFG_W + DATA_W;
`else
  localparam int unsigned ENTRY_W = DATA_W;
`endif

  feeder_state_e     r_state;
  feeder_state_e     w_state_nxt;
  logic [DATA_W-1:0] r_tx_data;
  logic [CFG_W-1:0]  r_tx_cfg;
  logic              r_overflow;
  logic              r_tx_irq;

  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_head;
  logic [DATA_W-1:0]  w_load_data;
  logic [CFG_W-1:0]   w_load_cfg;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;
  logic               w_push_ok;
  logic               w_ovf_set;
  logic               w_tx_enable;
  logic               w_pop;
  logic               w_load;
  logic               w_irq_set;

`ifdef UART_TX_CFG_PER_BYTE_EN
  tx_entry_t w_head_e;
  assign w_wdata     = tx_entry_t'{cfg: bus.cfg_reg, data: bus.wr_data};
  assign w_head_e    = tx_entry_t'(w_head);
  assign w_load_data = w_head_e.data;
  assign w_load_cfg  = w_head_e.cfg;
`else
  assign w_wdata     = bus.wr_data;
  assign w_load_data = w_head;
  assign w_load_cfg  = bus.cfg_reg;
`endif

  uart_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (bus.wr_en),
    .i_pop     (w_pop),
    .i_flush   (bus.flush),
    .i_wdata   (w_wdata),
    .o_rdata_c (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  // Push acceptance and overflow detection against the registered full flag.
  always_comb begin
    w_push_ok = bus.wr_en && !w_full && !bus.flush;
    w_ovf_set = bus.wr_en && w_full && !bus.flush;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (!w_empty && !bus.flush) w_state_nxt = LAUNCH;
      LAUNCH:    w_state_nxt = WAIT_DONE;
      WAIT_DONE: if (bus.tx_done) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // State-decoded controls: head load, launch pulse, pop and interrupt request.
  always_comb begin
    w_tx_enable = 1'b0;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_irq_set   = 1'b0;
    case (r_state)
      IDLE:      w_load = !w_empty && !bus.flush;
      LAUNCH: begin
        w_tx_enable = 1'b1;
        w_pop       = 1'b1;
      end
      WAIT_DONE: w_irq_set = bus.tx_done && (w_count == '0) && !w_push_ok;
      default:   ;
    endcase
  end

  // Launch payload, sticky overflow and interrupt pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_data  <= '0;
      r_tx_cfg   <= '0;
      r_overflow <= 1'b0;
      r_tx_irq   <= 1'b0;
    end else begin
      if (w_load) begin
        r_tx_data <= w_load_data;
        r_tx_cfg  <= w_load_cfg;
      end
      if (bus.ovf_clr)    r_overflow <= 1'b0;
      else if (w_ovf_set) r_overflow <= 1'b1;
      r_tx_irq <= w_irq_set;
    end
  end

  assign bus.tx_enable = w_tx_enable;
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_cfg    = r_tx_cfg;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.count     = w_count;
  assign bus.overflow  = r_overflow;
  assign bus.tx_irq    = r_tx_irq;

endmodule
